// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: oversampled UART receiver (LSB first, optional parity)
// feeding a small word FIFO that is drained through a pending/request
// handshake.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   rx                serial line (idles high, asynchronous to clk)
//   req_data          pop request, one pop per cycle sampled high
//   data_out_rx       last popped word, held until the next pop
//   pending_data_rx   high while the FIFO holds at least one word
//   parity_error_rx   one-cycle pulse on a parity failure
//   framing_error_rx  one-cycle pulse when the stop bit samples low
//   overflow_rx       one-cycle pulse when a good word is dropped (FIFO full)
//   fifo_count        number of words held
module uart_rx_buffered #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned PARITY     = 1,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          req_data,
    output logic [DATA_WIDTH-1:0]         data_out_rx,
    output logic                          pending_data_rx,
    output logic                          parity_error_rx,
    output logic                          framing_error_rx,
    output logic                          overflow_rx,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned SAMPLE_RATE = BAUD_RATE * OVERSAMPLE;
    localparam int unsigned DIV         = (CLOCK_FREQ + SAMPLE_RATE / 2) / SAMPLE_RATE;
    localparam int unsigned TICK_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SMP_W       = $clog2(OVERSAMPLE);
    localparam int unsigned MID         = OVERSAMPLE / 2;
    localparam int unsigned BIT_CLKS    = DIV * OVERSAMPLE;
    localparam int unsigned IDLE_W      = $clog2(BIT_CLKS + 1);
    localparam int unsigned IDX_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned AW          = $clog2(FIFO_DEPTH);
    localparam int unsigned CW          = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Receiver state
    logic [1:0]            sync_q, sync_d;
    logic                  rx_q, rx_d;
    state_t                state_q, state_d;
    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [SMP_W-1:0]      sample_cnt_q, sample_cnt_d;
    logic [1:0]            smp_q, smp_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_bit_q, par_bit_d;
    logic                  armed_q, armed_d;
    logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;

    // FIFO state
    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  pending_q, pending_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    logic rx_s;
    logic tick_c;
    logic mid_c;
    logic maj_c;
    logic par_ok_c;
    logic push_c;
    logic pop_c;
    logic full_c;
    logic wr_en_c;

    assign rx_s     = sync_q[1];
    assign tick_c   = (tick_cnt_q == TICK_W'(DIV - 1));
    // Bit decision point: the tick that brings the sample counter to mid-bit
    assign mid_c    = (state_q != S_IDLE) && tick_c && (sample_cnt_q == SMP_W'(MID - 1));
    // Majority of the three samples straddling mid-bit (two stored plus the current one)
    assign maj_c    = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s) | (smp_q[0] & rx_s);
    assign par_ok_c = ((^shreg_q) ^ par_bit_q) == (PARITY == 2);

    // Receive FSM, tick and sample counters
    always_comb begin
        sync_d       = {sync_q[0], rx};
        rx_d         = rx_s;
        state_d      = state_q;
        tick_cnt_d   = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
        sample_cnt_d = sample_cnt_q;
        smp_d        = smp_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        par_bit_d    = par_bit_q;
        armed_d      = armed_q;
        idle_cnt_d   = idle_cnt_q;
        perr_d       = 1'b0;
        ferr_d       = 1'b0;
        push_c       = 1'b0;

        if (state_q != S_IDLE && tick_c) begin
            sample_cnt_d = (sample_cnt_q == SMP_W'(OVERSAMPLE - 1)) ? '0
                                                                   : sample_cnt_q + SMP_W'(1);
            smp_d        = {smp_q[0], rx_s};
        end

        unique case (state_q)
            S_IDLE: begin
                if (!armed_q) begin
                    // After a framing error, wait for one full bit period of idle line
                    if (!rx_s) begin
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == IDLE_W'(BIT_CLKS - 1)) begin
                        idle_cnt_d = '0;
                        armed_d    = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end else if (rx_q && !rx_s) begin
                    state_d      = S_START;
                    tick_cnt_d   = '0;
                    sample_cnt_d = '0;
                end
            end
            S_START: begin
                if (mid_c) begin
                    if (maj_c) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (mid_c) begin
                    shreg_d[bit_idx_q] = maj_c;
                    if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (mid_c) begin
                    par_bit_d = maj_c;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (mid_c) begin
                    // Framing beats parity so a frame raises at most one error
                    if (!maj_c) begin
                        ferr_d     = 1'b1;
                        armed_d    = 1'b0;
                        idle_cnt_d = '0;
                    end else if (PARITY != 0 && !par_ok_c) begin
                        perr_d = 1'b1;
                    end else begin
                        push_c = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO: push from the receiver, pop on req_data; no bypass when empty
    always_comb begin
        pop_c      = req_data && (count_q != '0);
        full_c     = (count_q == CW'(FIFO_DEPTH));
        wr_en_c    = push_c && (!full_c || pop_c);
        ovf_d      = push_c && full_c && !pop_c;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;

        if (wr_en_c) begin
            mem_d[wr_ptr_q] = shreg_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            data_out_d = mem_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + AW'(1);
        end
        unique case ({wr_en_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        pending_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= 2'b11;
            rx_q         <= 1'b1;
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            sample_cnt_q <= '0;
            smp_q        <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            par_bit_q    <= 1'b0;
            armed_q      <= 1'b1;
            idle_cnt_q   <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            mem_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pending_q    <= 1'b0;
            ovf_q        <= 1'b0;
            data_out_q   <= '0;
        end else begin
            sync_q       <= sync_d;
            rx_q         <= rx_d;
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            smp_q        <= smp_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            par_bit_q    <= par_bit_d;
            armed_q      <= armed_d;
            idle_cnt_q   <= idle_cnt_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pending_q    <= pending_d;
            ovf_q        <= ovf_d;
            data_out_q   <= data_out_d;
        end
    end

    assign data_out_rx      = data_out_q;
    assign pending_data_rx  = pending_q;
    assign parity_error_rx  = perr_q;
    assign framing_error_rx = ferr_q;
    assign overflow_rx      = ovf_q;
    assign fifo_count       = count_q;

endmodule
